// File: rtl/dist_frame_packer_if.sv
// dist_frame_packer_if
// Byte-frame handshake between dist_frame_packer and the W5500 TX path.
//   o_dat_tx_req : frame ready, held high until the frame is sent
//   o_dat        : current frame byte (first-word-fall-through)
//   o_dat_len    : frame length in bytes
//   dat_tx_rden  : W5500 consumed the current byte
//   dat_tx_end   : W5500 finished sending the frame
// Modports: master = packer side, slave = W5500 side.
interface dist_frame_packer_if;
    logic        o_dat_tx_req;
    logic [7:0]  o_dat;
    logic [15:0] o_dat_len;
    logic        dat_tx_rden;
    logic        dat_tx_end;

    modport master (
        output o_dat_tx_req, o_dat, o_dat_len,
        input  dat_tx_rden, dat_tx_end
    );

    modport slave (
        input  o_dat_tx_req, o_dat, o_dat_len,
        output dat_tx_rden, dat_tx_end
    );
endinterface

// File: rtl/dist_frame_packer.sv
// dist_frame_packer
// Captures 19-bit samples between flag_start and flag_end, then presents
// one checksummed byte frame to the W5500 TX path:
//   A5 5A SEQ N {5'b0,d[18:16]} d[15:8] d[7:0] ... CKS
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   data_in, data_vld   : sample and its valid strobe
//   flag_start/flag_end : capture window open/close pulses
//   tx (master modport) : W5500 request/byte/length/read-enable/end handshake
//   o_busy              : high whenever not IDLE
//   o_ovf               : sticky sample-dropped flag, cleared by a new window
//   o_tx_timeout        : one-cycle pulse when a frame is abandoned
// Optional feature: define FRAME_TIMEOUT_EN to abandon a frame whose
// dat_tx_end does not arrive within TIMEOUT_CYC cycles of entering REQ.
module dist_frame_packer #(
    parameter int MAX_SAMPLES = 16,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [18:0]          data_in,
    input  logic                 data_vld,
    input  logic                 flag_start,
    input  logic                 flag_end,
    dist_frame_packer_if.master  tx,
    output logic                 o_busy,
    output logic                 o_ovf,
    output logic                 o_tx_timeout
);

    typedef enum logic [2:0] {IDLE, CAPTURE, CLOSE, REQ, SEND} state_t;

    state_t      state, state_nxt;
    logic [18:0] sample_buf [MAX_SAMPLES];
    logic [6:0]  n_cnt;
    logic [7:0]  sum, seq, cks, ptr, last_ptr;
    logic [1:0]  byte_sel;
    logic [6:0]  rd_idx;
    logic [15:0] len_q;
    logic        ovf_q;
    logic        cap_ok, wr_en, sending, timeout_hit;
    logic [6:0]  wr_idx, n_after;
    logic [7:0]  samp_sum, byte_cur;
    logic [18:0] rd_word;

    assign sending  = (state == REQ) || (state == SEND);
    assign cap_ok   = data_vld && (n_cnt < 7'(MAX_SAMPLES));
    assign n_after  = n_cnt + {6'd0, cap_ok};
    assign samp_sum = {5'd0, data_in[18:16]} + data_in[15:8] + data_in[7:0];
    // A repeated flag_start restarts the window, so its sample lands at 0.
    assign wr_en    = (state == CAPTURE) && data_vld && (flag_start || cap_ok);
    assign wr_idx   = flag_start ? 7'd0 : n_cnt;

`ifdef FRAME_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        tmo_pulse;

    assign timeout_hit = sending && (tmo_cnt == 32'(TIMEOUT_CYC - 1));

    // Counter is zero on the first REQ cycle; a dat_tx_end arriving in the
    // expiry cycle wins and the frame completes normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            tmo_pulse <= 1'b0;
        end else begin
            tmo_pulse <= timeout_hit && !tx.dat_tx_end;
            if (state == CLOSE)
                tmo_cnt <= '0;
            else if (sending)
                tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign o_tx_timeout = tmo_pulse;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
    assign o_tx_timeout       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flag_start) state_nxt = CAPTURE;
            CAPTURE: begin
                if (!flag_start && flag_end)
                    state_nxt = (n_after == 7'd0) ? IDLE : CLOSE;
            end
            CLOSE:   state_nxt = REQ;
            REQ: begin
                if (tx.dat_tx_end || timeout_hit) state_nxt = IDLE;
                else if (tx.dat_tx_rden)          state_nxt = SEND;
            end
            SEND:    if (tx.dat_tx_end || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sample storage has no reset; only indices below n_cnt are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_SAMPLES; i++)
            if (wr_en && (wr_idx == 7'(i)))
                sample_buf[i] <= data_in;
    end

    // Capture bookkeeping, checksum/length latch and byte pointer.
    // byte_sel/rd_idx follow the pointer through the sample region so the
    // buffer address never needs a divide by three.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_cnt    <= '0;
            sum      <= '0;
            seq      <= '0;
            cks      <= '0;
            ptr      <= '0;
            last_ptr <= '0;
            byte_sel <= '0;
            rd_idx   <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flag_start) begin
                        n_cnt <= '0;
                        sum   <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (flag_start) begin
                        n_cnt <= data_vld ? 7'd1 : 7'd0;
                        sum   <= data_vld ? samp_sum : 8'd0;
                    end else if (data_vld) begin
                        if (cap_ok) begin
                            n_cnt <= n_cnt + 7'd1;
                            sum   <= sum + samp_sum;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                CLOSE: begin
                    // 8'hFF is the header constant A5 + 5A.
                    cks      <= sum + 8'hFF + seq + {1'b0, n_cnt};
                    len_q    <= 16'd5 + 16'd3 * {9'd0, n_cnt};
                    last_ptr <= 8'd4 + 8'd3 * {1'b0, n_cnt};
                    ptr      <= '0;
                    byte_sel <= '0;
                    rd_idx   <= '0;
                end
                REQ, SEND: begin
                    if (tx.dat_tx_end) begin
                        seq <= seq + 8'd1;
                    end else if (tx.dat_tx_rden && (ptr != last_ptr)) begin
                        ptr <= ptr + 8'd1;
                        if (ptr >= 8'd4) begin
                            if (byte_sel == 2'd2) begin
                                byte_sel <= '0;
                                rd_idx   <= rd_idx + 7'd1;
                            end else begin
                                byte_sel <= byte_sel + 2'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < MAX_SAMPLES; i++)
            if (rd_idx == 7'(i))
                rd_word = sample_buf[i];
    end

    // Frame byte at the current pointer; the checksum test comes first
    // because the last pointer value may coincide with a sample position.
    always_comb begin
        byte_cur = 8'h00;
        if (sending) begin
            if (ptr == last_ptr)
                byte_cur = cks;
            else begin
                case (ptr)
                    8'd0:    byte_cur = 8'hA5;
                    8'd1:    byte_cur = 8'h5A;
                    8'd2:    byte_cur = seq;
                    8'd3:    byte_cur = {1'b0, n_cnt};
                    default: begin
                        case (byte_sel)
                            2'd0:    byte_cur = {5'd0, rd_word[18:16]};
                            2'd1:    byte_cur = rd_word[15:8];
                            default: byte_cur = rd_word[7:0];
                        endcase
                    end
                endcase
            end
        end
    end

    assign tx.o_dat_tx_req = sending;
    assign tx.o_dat        = byte_cur;
    assign tx.o_dat_len    = len_q;
    assign o_busy          = (state != IDLE);
    assign o_ovf           = ovf_q;

endmodule

// File: tb/tb_dist_frame_packer.sv
// tb_dist_frame_packer
// Directed bench for dist_frame_packer (MAX_SAMPLES=16, TIMEOUT_CYC=100).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// Compile with FRAME_TIMEOUT_EN defined to also exercise the frame timeout.
module tb_dist_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [18:0] data_in = '0;
    logic        data_vld = 1'b0;
    logic        flag_start = 1'b0;
    logic        flag_end = 1'b0;
    logic        o_busy, o_ovf, o_tx_timeout;

    int total = 0;
    int bad = 0;

    logic [7:0]  exp_bytes [$];
    logic [18:0] smp [$];

    dist_frame_packer_if tx_bus ();

    dist_frame_packer #(
        .MAX_SAMPLES (16),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_vld     (data_vld),
        .flag_start   (flag_start),
        .flag_end     (flag_end),
        .tx           (tx_bus),
        .o_busy       (o_busy),
        .o_ovf        (o_ovf),
        .o_tx_timeout (o_tx_timeout)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends even if the design wedges.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle with the given inputs, then all pulses return low.
    task automatic applyStimulus(input logic start, input logic stop, input logic vld,
                                 input logic [18:0] d, input logic rden, input logic txend);
        flag_start         = start;
        flag_end           = stop;
        data_vld           = vld;
        data_in            = d;
        tx_bus.dat_tx_rden = rden;
        tx_bus.dat_tx_end  = txend;
        @(posedge clk);
        #1;
        flag_start         = 1'b0;
        flag_end           = 1'b0;
        data_vld           = 1'b0;
        data_in            = '0;
        tx_bus.dat_tx_rden = 1'b0;
        tx_bus.dat_tx_end  = 1'b0;
    endtask

    // Reference frame from the byte format: header, samples MSB first, sum.
    function automatic void build_expected(input logic [7:0] seq);
        logic [7:0] cks;
        exp_bytes.delete();
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h5A);
        exp_bytes.push_back(seq);
        exp_bytes.push_back(8'(smp.size()));
        foreach (smp[i]) begin
            exp_bytes.push_back({5'd0, smp[i][18:16]});
            exp_bytes.push_back(smp[i][15:8]);
            exp_bytes.push_back(smp[i][7:0]);
        end
        cks = 8'h00;
        foreach (exp_bytes[i]) cks = cks + exp_bytes[i];
        exp_bytes.push_back(cks);
    endfunction

    task automatic wait_req();
        for (int i = 0; i < 20 && tx_bus.o_dat_tx_req !== 1'b1; i++)
            applyStimulus(0, 0, 0, '0, 0, 0);
        checkOutput("req_rise", {31'd0, tx_bus.o_dat_tx_req}, 32'd1);
    endtask

    // Reads exp_bytes from byte index 'from', checks saturation, completes.
    task automatic drain_frame(input string tag, input int from);
        for (int i = from; i < exp_bytes.size(); i++) begin
            checkOutput($sformatf("%s_b%0d", tag, i), {24'd0, tx_bus.o_dat}, {24'd0, exp_bytes[i]});
            applyStimulus(0, 0, 0, '0, 1, 0);
        end
        applyStimulus(0, 0, 0, '0, 1, 0);
        checkOutput({tag, "_sat"}, {24'd0, tx_bus.o_dat}, {24'd0, exp_bytes[exp_bytes.size()-1]});
        applyStimulus(0, 0, 0, '0, 0, 1);
        checkOutput({tag, "_req_drop"}, {31'd0, tx_bus.o_dat_tx_req}, 32'd0);
        checkOutput({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic read_frame(input string tag);
        wait_req();
        checkOutput({tag, "_len"}, {16'd0, tx_bus.o_dat_len}, 32'(exp_bytes.size()));
        drain_frame(tag, 0);
    endtask

    task automatic one_sample_frame(input logic [18:0] d);
        applyStimulus(1, 0, 0, '0, 0, 0);
        applyStimulus(0, 0, 1, d, 0, 0);
        applyStimulus(0, 1, 0, '0, 0, 0);
    endtask

    initial begin
        tx_bus.dat_tx_rden = 1'b0;
        tx_bus.dat_tx_end  = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_req", {31'd0, tx_bus.o_dat_tx_req}, 32'd0);
        checkOutput("rst_dat", {24'd0, tx_bus.o_dat}, 32'h00);
        checkOutput("rst_len", {16'd0, tx_bus.o_dat_len}, 32'd0);
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("rst_ovf", {31'd0, o_ovf}, 32'd0);
        checkOutput("rst_tmo", {31'd0, o_tx_timeout}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, '0, 0, 0);

        // Two-sample frame, hand-computed bytes, SEQ=00
        $display("[TB] two-sample frame");
        applyStimulus(1, 0, 0, '0, 0, 0);
        checkOutput("cap_busy", {31'd0, o_busy}, 32'd1);
        applyStimulus(0, 0, 1, 19'h12345, 0, 0);
        applyStimulus(0, 0, 1, 19'h00001, 0, 0);
        applyStimulus(0, 1, 0, '0, 0, 0);
        checkOutput("close_req", {31'd0, tx_bus.o_dat_tx_req}, 32'd0);
        applyStimulus(0, 0, 0, '0, 0, 0);
        checkOutput("req_after_close", {31'd0, tx_bus.o_dat_tx_req}, 32'd1);
        exp_bytes = {8'hA5, 8'h5A, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45,
                     8'h00, 8'h00, 8'h01, 8'h6B};
        checkOutput("f1_len", {16'd0, tx_bus.o_dat_len}, 32'd11);
        drain_frame("f1", 0);

        // Sample with start in IDLE is ignored; sample with end is kept
        $display("[TB] start/end same-cycle capture");
        applyStimulus(1, 0, 1, 19'h11111, 0, 0);
        applyStimulus(0, 1, 1, 19'h7FFFF, 0, 0);
        exp_bytes = {8'hA5, 8'h5A, 8'h01, 8'h01, 8'h07, 8'hFF, 8'hFF, 8'h06};
        read_frame("f2");

        // Empty window sends nothing and keeps SEQ
        $display("[TB] empty window");
        applyStimulus(1, 0, 0, '0, 0, 0);
        applyStimulus(0, 1, 0, '0, 0, 0);
        checkOutput("empty_idle", {31'd0, o_busy}, 32'd0);
        applyStimulus(0, 0, 0, '0, 0, 0);
        applyStimulus(0, 0, 0, '0, 0, 0);
        checkOutput("empty_noreq", {31'd0, tx_bus.o_dat_tx_req}, 32'd0);

        // Start+end together keeps the window open, then overflow
        $display("[TB] overflow window");
        applyStimulus(1, 0, 0, '0, 0, 0);
        applyStimulus(1, 1, 0, '0, 0, 0);
        checkOutput("startend_open", {31'd0, o_busy}, 32'd1);
        smp.delete();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(0, 0, 1, 19'(i * 4663 + 3), 0, 0);
            if (i < 16) smp.push_back(19'(i * 4663 + 3));
            if (i == 15) checkOutput("ovf_at16", {31'd0, o_ovf}, 32'd0);
            if (i == 16) checkOutput("ovf_at17", {31'd0, o_ovf}, 32'd1);
        end
        applyStimulus(0, 1, 0, '0, 0, 0);
        build_expected(8'h02);
        read_frame("ovf");
        checkOutput("ovf_sticky", {31'd0, o_ovf}, 32'd1);
        applyStimulus(1, 0, 0, '0, 0, 0);
        checkOutput("ovf_cleared", {31'd0, o_ovf}, 32'd0);

        // Restart keeps that cycle's sample; inputs during SEND are ignored
        $display("[TB] restart and SEND poke");
        applyStimulus(0, 0, 1, 19'h00AAA, 0, 0);
        applyStimulus(1, 0, 1, 19'h00055, 0, 0);
        applyStimulus(0, 1, 0, '0, 0, 0);
        exp_bytes = {8'hA5, 8'h5A, 8'h03, 8'h01, 8'h00, 8'h00, 8'h55, 8'h58};
        wait_req();
        checkOutput("rs_len", {16'd0, tx_bus.o_dat_len}, 32'd8);
        applyStimulus(0, 0, 0, '0, 1, 0);
        applyStimulus(0, 0, 0, '0, 1, 0);
        applyStimulus(1, 1, 1, 19'h7ABCD, 0, 0);
        checkOutput("poke_req", {31'd0, tx_bus.o_dat_tx_req}, 32'd1);
        drain_frame("rs", 2);

        // SEQ runs through FF and wraps to 00
        $display("[TB] sequence wrap");
        for (int k = 4; k <= 256; k++) begin
            smp.delete();
            smp.push_back(19'(k * 7));
            one_sample_frame(19'(k * 7));
            build_expected(8'(k));
            read_frame($sformatf("seq%0d", k));
        end

        // Reset during SEND after four bytes
        $display("[TB] reset mid-frame");
        smp.delete();
        smp.push_back(19'h40F0F);
        one_sample_frame(19'h40F0F);
        wait_req();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, '0, 1, 0);
        rst_n = 1'b0;
        #2;
        checkOutput("mr_req", {31'd0, tx_bus.o_dat_tx_req}, 32'd0);
        checkOutput("mr_dat", {24'd0, tx_bus.o_dat}, 32'h00);
        checkOutput("mr_len", {16'd0, tx_bus.o_dat_len}, 32'd0);
        checkOutput("mr_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("mr_ovf", {31'd0, o_ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        one_sample_frame(19'h40F0F);
        build_expected(8'h00);
        read_frame("after_rst");

`ifdef FRAME_TIMEOUT_EN
        // Unanswered frame is abandoned after 100 REQ/SEND cycles
        $display("[TB] frame timeout");
        begin
            int cyc;
            one_sample_frame(19'h00123);
            wait_req();
            cyc = 0;
            while (tx_bus.o_dat_tx_req === 1'b1 && cyc < 200) begin
                applyStimulus(0, 0, 0, '0, 0, 0);
                cyc++;
            end
            checkOutput("tmo_cycles", 32'(cyc), 32'd100);
            checkOutput("tmo_pulse", {31'd0, o_tx_timeout}, 32'd1);
            applyStimulus(0, 0, 0, '0, 0, 0);
            checkOutput("tmo_pulse_end", {31'd0, o_tx_timeout}, 32'd0);
            smp.delete();
            smp.push_back(19'h00123);
            one_sample_frame(19'h00123);
            build_expected(8'h01);
            read_frame("tmo_reuse");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
